// File: rtl/avg_pool1d_window_ctrl_if.sv
// Handshake bundle for the 1-D average-pool window sequencer:
// serial element stream in, KERNEL_SIZE-lane window vector out.
interface avg_pool1d_window_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 2
);
    logic [DATA_WIDTH-1:0] data_in_0;
    logic                  data_in_0_valid;
    logic                  data_in_0_ready;
    logic [DATA_WIDTH-1:0] data_out_0 [LANES-1:0];
    logic                  data_out_0_valid;
    logic                  data_out_0_ready;
    logic                  data_out_0_last;

    // master drives the element stream and consumes windows; slave is the sequencer
    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
    );
    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
    );
endinterface

// File: rtl/avg_pool1d_window_ctrl.sv
// Window sequencer for the 1-D average-pool core: zero-pads each row, slides a
// KERNEL_SIZE window at STRIDE and presents every complete window downstream.
module avg_pool1d_window_ctrl #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int KERNEL_SIZE                 = 2,
    parameter int STRIDE                      = 2,
    parameter int PADDING                     = 0
) (
    input logic                     clk,
    input logic                     rst,
    avg_pool1d_window_ctrl_if.slave io
);
    localparam int W = DATA_IN_0_PRECISION_0;
    localparam int L = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int R = DATA_IN_0_TENSOR_SIZE_DIM_1;
    localparam int K = KERNEL_SIZE;
    localparam int S = STRIDE;
    localparam int P = PADDING;

    localparam int LP        = L + 2 * P;
    localparam int L_OUT     = (S >= 1 && LP >= K) ? (LP - K) / S + 1 : 1;
    localparam int LAST_END  = (L_OUT - 1) * S + K - 1;
    // Trailing real elements are always drained; trailing pads only when a window needs them.
    localparam int ROW_END   = (LAST_END > P + L - 1) ? LAST_END : P + L - 1;
    localparam int PAD_L_END = (P > 0) ? P - 1 : 0;
    localparam int FEED_END  = P + L - 1;
    localparam int PW        = $clog2(LP + S) + 1;
    localparam int WW        = $clog2(L_OUT) + 1;
    localparam int RW        = $clog2(R) + 1;

    if (P >= K || K > LP || S < 1 || L < 1) begin : g_bad_cfg
        $error("avg_pool1d_window_ctrl: illegal KERNEL_SIZE/STRIDE/PADDING/row length");
    end

    typedef enum logic [1:0] {PAD_L, FEED, PAD_R} state_t;
    localparam state_t ROW_START = (P > 0) ? PAD_L : FEED;

    state_t         state;
    state_t         state_next;
    logic [PW-1:0]  pos;
    logic [PW-1:0]  next_end;
    logic [WW-1:0]  win_idx;
    logic [RW-1:0]  row;
    logic [W-1:0]   win      [K-1:0];
    logic [W-1:0]   win_next [K-1:0];
    logic           is_real;
    logic           out_free;
    logic           adv;
    logic           win_done;
    logic           row_done;
    logic [W-1:0]   shift_val;

    always_ff @(posedge clk) begin
        if (rst) state <= ROW_START;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (adv) begin
            if (pos == PW'(ROW_END))                              state_next = ROW_START;
            else if (state == PAD_L && pos == PW'(PAD_L_END))     state_next = FEED;
            else if (state == FEED  && pos == PW'(FEED_END))      state_next = PAD_R;
        end
    end

    always_comb begin
        is_real            = (state == FEED);
        out_free           = !io.data_out_0_valid || io.data_out_0_ready;
        io.data_in_0_ready = is_real && out_free;
        adv                = (is_real ? io.data_in_0_valid : 1'b1) && out_free;
        shift_val          = is_real ? io.data_in_0 : '0;
        win_done           = adv && (pos == next_end) && (win_idx < WW'(L_OUT));
        row_done           = adv && (pos == PW'(ROW_END));
    end

    always_comb begin
        for (int i = 0; i < K - 1; i++) win_next[i] = win[i + 1];
        win_next[K-1] = shift_val;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos                 <= '0;
            next_end            <= PW'(K - 1);
            win_idx             <= '0;
            row                 <= '0;
            // NOTE: the window array is small and must read as zeros after reset, so it is reset explicitly.
            win                 <= '{default: '0};
            io.data_out_0       <= '{default: '0};
            io.data_out_0_valid <= 1'b0;
            io.data_out_0_last  <= 1'b0;
        end else begin
            if (win_done) begin
                io.data_out_0       <= win_next;
                io.data_out_0_valid <= 1'b1;
                io.data_out_0_last  <= (row == RW'(R - 1)) && (win_idx == WW'(L_OUT - 1));
            end else if (io.data_out_0_ready) begin
                io.data_out_0_valid <= 1'b0;
                io.data_out_0_last  <= 1'b0;
            end

            if (row_done) begin
                pos      <= '0;
                next_end <= PW'(K - 1);
                win_idx  <= '0;
                win      <= '{default: '0};
                row      <= (row == RW'(R - 1)) ? '0 : row + RW'(1);
            end else if (adv) begin
                pos <= pos + PW'(1);
                win <= win_next;
                if (win_done) begin
                    win_idx  <= win_idx + WW'(1);
                    next_end <= next_end + PW'(S);
                end
            end
        end
    end
endmodule

// File: tb/tb_avg_pool1d_window_ctrl.sv
// Self-checking bench for avg_pool1d_window_ctrl: directed edge cases plus
// randomized tensors scored against a padded-row window model.
module tb_avg_pool1d_window_ctrl;
    localparam int W     = 8;
    localparam int L     = 7;
    localparam int R     = 2;
    localparam int K     = 3;
    localparam int S     = 2;
    localparam int P     = 1;
    localparam int L_OUT = (L + 2 * P - K) / S + 1;
    localparam int KB    = 2;

    typedef logic [K-1:0][W-1:0] lanes_t;
    typedef struct packed {
        lanes_t lanes;
        logic   last;
    } win_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [W-1:0] src_q[$];
    win_t         exp_q[$];

    logic   s_valid;
    logic   s_last;
    logic   s_in_ready;
    lanes_t s_lanes;
    bit     prev_stall;
    lanes_t prev_lanes;
    logic   prev_last;

    avg_pool1d_window_ctrl_if #(.DATA_WIDTH(W), .LANES(K))  io ();
    avg_pool1d_window_ctrl_if #(.DATA_WIDTH(W), .LANES(KB)) io_b ();

    avg_pool1d_window_ctrl #(
        .DATA_IN_0_PRECISION_0(W), .DATA_IN_0_TENSOR_SIZE_DIM_0(L),
        .DATA_IN_0_TENSOR_SIZE_DIM_1(R), .KERNEL_SIZE(K), .STRIDE(S), .PADDING(P)
    ) dut (.clk(clk), .rst(rst), .io(io));

    avg_pool1d_window_ctrl #(
        .DATA_IN_0_PRECISION_0(W), .DATA_IN_0_TENSOR_SIZE_DIM_0(4),
        .DATA_IN_0_TENSOR_SIZE_DIM_1(1), .KERNEL_SIZE(KB), .STRIDE(1), .PADDING(0)
    ) dut_b (.clk(clk), .rst(rst), .io(io_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic lanes_t lanes_of_a();
        lanes_t v;
        for (int j = 0; j < K; j++) v[j] = io.data_out_0[j];
        return v;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        io.data_in_0 = '0;   io.data_in_0_valid = 1'b0;   io.data_out_0_ready = 1'b0;
        io_b.data_in_0 = '0; io_b.data_in_0_valid = 1'b0; io_b.data_out_0_ready = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
    endtask

    // Reference: each row is laid out with its zero pads, window w is padded[w*S +: K].
    task automatic push_tensor(input bit rnd);
        logic [W-1:0] e      [R][L];
        logic [W-1:0] padded [L + 2 * P];
        win_t         x;
        for (int r = 0; r < R; r++)
            for (int i = 0; i < L; i++) begin
                e[r][i] = rnd ? W'($urandom) : W'(r * 10 + i + 1);
                src_q.push_back(e[r][i]);
            end
        for (int r = 0; r < R; r++) begin
            for (int q = 0; q < L + 2 * P; q++) begin
                if (q < P || q >= P + L) padded[q] = '0;
                else                     padded[q] = e[r][q - P];
            end
            for (int w = 0; w < L_OUT; w++) begin
                for (int j = 0; j < K; j++) x.lanes[j] = padded[w * S + j];
                x.last = (r == R - 1) && (w == L_OUT - 1);
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic cycle(input bit v, input bit r);
        win_t e;
        io.data_in_0_valid  = v && (src_q.size() > 0);
        io.data_in_0        = (src_q.size() > 0) ? src_q[0] : '0;
        io.data_out_0_ready = r;
        @(negedge clk);
        s_valid    = io.data_out_0_valid;
        s_last     = io.data_out_0_last;
        s_in_ready = io.data_in_0_ready;
        s_lanes    = lanes_of_a();
        if (prev_stall) begin
            check("hold_valid", s_valid, 1'b1);
            check("hold_lanes", s_lanes, prev_lanes);
            check("hold_last", s_last, prev_last);
        end
        if (s_valid && !r) check("stall_in_ready", s_in_ready, 1'b0);
        prev_stall = s_valid && !r;
        prev_lanes = s_lanes;
        prev_last  = s_last;
        if (s_valid && r) begin
            if (exp_q.size() == 0) check("extra_window", s_valid, 1'b0);
            else begin
                e = exp_q.pop_front();
                check("win_lanes", s_lanes, e.lanes);
                check("win_last", s_last, e.last);
            end
        end
        if (io.data_in_0_valid && s_in_ready) void'(src_q.pop_front());
        tick();
    endtask

    task automatic drain(input int pv, input int pr);
        int n = 0;
        while ((exp_q.size() > 0 || src_q.size() > 0) && n < 2000) begin
            cycle($urandom_range(99) < pv, $urandom_range(99) < pr);
            n++;
        end
        check("drain_windows_left", exp_q.size(), 0);
        check("drain_elems_left", src_q.size(), 0);
    endtask

    task automatic step_b(input bit v, input logic [W-1:0] d, input bit r, input string tag,
                          input logic ev, input logic [2*W-1:0] el, input logic elast,
                          input logic erdy);
        io_b.data_in_0_valid  = v;
        io_b.data_in_0        = d;
        io_b.data_out_0_ready = r;
        @(negedge clk);
        check({tag, "_valid"}, io_b.data_out_0_valid, ev);
        if (ev) begin
            check({tag, "_lanes"}, {io_b.data_out_0[1], io_b.data_out_0[0]}, el);
            check({tag, "_last"}, io_b.data_out_0_last, elast);
        end
        check({tag, "_in_ready"}, io_b.data_in_0_ready, erdy);
        tick();
    endtask

    initial begin
        int n;
        do_reset(2);

        // Reset state, sampled before the first edge after release.
        @(negedge clk);
        check("rst_valid", io.data_out_0_valid, 1'b0);
        check("rst_last", io.data_out_0_last, 1'b0);
        check("rst_lanes", lanes_of_a(), '0);
        check("rst_in_ready_pad", io.data_in_0_ready, 1'b0);
        check("rst_b_in_ready", io_b.data_in_0_ready, 1'b1);
        tick();

        // K=2,S=1 instance: 5-cycle stall on {1,2}, then zero-bubble windows.
        step_b(1, 8'd1, 0, "b_c0", 0, 16'h0000, 0, 1);
        step_b(1, 8'd2, 0, "b_c1", 0, 16'h0000, 0, 1);
        for (int i = 0; i < 5; i++) step_b(1, 8'd3, 0, "b_stall", 1, 16'h0201, 0, 0);
        step_b(1, 8'd3, 1, "b_rel", 1, 16'h0201, 0, 1);
        step_b(1, 8'd4, 1, "b_w1", 1, 16'h0302, 0, 1);
        step_b(0, 8'd0, 1, "b_w2", 1, 16'h0403, 1, 1);
        step_b(0, 8'd0, 1, "b_idle", 0, 16'h0000, 0, 1);

        // Row start: one pad cycle, then the first window one cycle after its last element.
        do_reset(1);
        push_tensor(0);
        cycle(1, 1);
        check("pad_cycle_ready", s_in_ready, 1'b0);
        check("pad_cycle_valid", s_valid, 1'b0);
        cycle(1, 1);
        check("feed1_ready", s_in_ready, 1'b1);
        cycle(1, 1);
        check("feed2_valid", s_valid, 1'b0);
        cycle(1, 1);
        check("first_win_valid", s_valid, 1'b1);
        check("first_win_lanes", s_lanes, 24'h020100);
        drain(70, 70);

        // Random tensors under random valid/ready.
        repeat (3) push_tensor(1);
        drain(60, 60);
        repeat (2) push_tensor(1);
        drain(100, 100);

        // Backpressure: hold the first window for five extra cycles.
        push_tensor(1);
        n = 0;
        do begin
            cycle(1, 0);
            n++;
        end while (!s_valid && n < 20);
        check("bp_window_seen", s_valid, 1'b1);
        repeat (5) cycle(1, 0);
        drain(100, 100);

        // Reset mid-row, then a fresh tensor starts from row 0.
        push_tensor(1);
        repeat (4) cycle(1, 1);
        do_reset(1);
        cycle(0, 1);
        check("post_reset_valid", s_valid, 1'b0);
        push_tensor(0);
        drain(100, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
